// File: rtl/seq_addsub_unit_pkg.sv
// Shared types and helpers for the sequential add/subtract unit.
// Pure declarations; no timing or flow-control behaviour of its own.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      EXT  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int num_slices(input int width, input int slice);
      return width / slice;
   endfunction

endpackage

// File: rtl/seq_addsub_unit_if.sv
// Control-unit facing bundle of the add/subtract unit: request, operands, status and results.
// master drives request/operands; slave returns busy/done plus result and flags.
interface seq_addsub_unit_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic                 op_sub;
   logic                 signed_op;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   result;
   logic                 carry;
   logic                 overflow;
   logic                 zero;
   logic                 negative;

   modport master (
      output start, op_sub, signed_op, a, b,
      input  busy, done, result, carry, overflow, zero, negative
   );

   modport slave (
      input  start, op_sub, signed_op, a, b,
      output busy, done, result, carry, overflow, zero, negative
   );
endinterface

// File: rtl/seq_addsub_unit_slice_adder.sv
// Combinational SLICE-bit ripple adder, zero latency, no flow control.
// Also exposes the carry into the MSB so the caller can form signed overflow.
module slice_adder #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] sum,
   output logic             cout,
   output logic             cin_msb
);

   always_comb begin
      logic [SLICE:0] c;
      c       = '0;
      c[0]    = cin;
      sum     = '0;
      for (int i = 0; i < SLICE; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout    = c[SLICE];
      cin_msb = c[SLICE-1];
   end

endmodule

// File: rtl/seq_addsub_unit.sv
// Multi-cycle add/subtract, one SLICE per clock; done pulses N+1 cycles after an accepted start.
// Start is only sampled in IDLE/DONE (ignored while busy); one op per N+2 cycles back-to-back.
module seq_addsub_unit
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   seq_addsub_unit_if.slave bus
);

   localparam int N     = num_slices(WIDTH, SLICE);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   if (WIDTH % SLICE != 0) begin : g_width_check
      $error("seq_addsub_unit: WIDTH must be a multiple of SLICE");
   end

   state_t             state;
   state_t             state_nxt;
   logic               accept;
   logic               last_slice;

   logic [IDX_W-1:0]   slice_idx;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   bp_reg;
   logic               b_msb;
   logic [WIDTH-1:0]   lo_reg;
   logic               op_sub_reg;
   logic               signed_reg;
   logic               carry_reg;
   logic               ovf_run;

   logic [2*WIDTH-1:0] result_q;
   logic               carry_q;
   logic               ovf_q;
   logic               zero_q;
   logic               neg_q;

   logic [SLICE-1:0]   sl_a;
   logic [SLICE-1:0]   sl_b;
   logic [SLICE-1:0]   sl_sum;
   logic               sl_cout;
   logic               sl_cin_msb;

   logic [WIDTH-1:0]   hi_a;
   logic [WIDTH-1:0]   hi_b;
   logic [WIDTH-1:0]   hi_sum;

   assign last_slice = (slice_idx == IDX_W'(N - 1));

   always_ff @(posedge clock) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN:  if (last_slice) state_nxt = EXT;
         EXT:  state_nxt = DONE;
         DONE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign sl_a = a_reg[int'(slice_idx) * SLICE +: SLICE];
   assign sl_b = bp_reg[int'(slice_idx) * SLICE +: SLICE];

   slice_adder #(.SLICE(SLICE)) u_slice (
      .a       (sl_a),
      .b       (sl_b),
      .cin     (carry_reg),
      .sum     (sl_sum),
      .cout    (sl_cout),
      .cin_msb (sl_cin_msb)
   );

   // Upper word only ever sees all-zeros or all-ones extension, so a plain add suffices.
   assign hi_a   = signed_reg ? {WIDTH{a_reg[WIDTH-1]}} : '0;
   assign hi_b   = signed_reg ? {WIDTH{b_msb}} : '0;
   assign hi_sum = hi_a + ((op_sub_reg == OP_SUB) ? ~hi_b : hi_b) + WIDTH'(carry_reg);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         slice_idx  <= '0;
         a_reg      <= '0;
         bp_reg     <= '0;
         b_msb      <= 1'b0;
         lo_reg     <= '0;
         op_sub_reg <= OP_ADD;
         signed_reg <= 1'b0;
         carry_reg  <= 1'b0;
         ovf_run    <= 1'b0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         ovf_q      <= 1'b0;
         zero_q     <= 1'b0;
         neg_q      <= 1'b0;
      end else if (accept) begin
         a_reg      <= bus.a;
         bp_reg     <= (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
         b_msb      <= bus.b[WIDTH-1];
         carry_reg  <= bus.op_sub;
         slice_idx  <= '0;
         op_sub_reg <= bus.op_sub;
         signed_reg <= bus.signed_op;
      end else if (state == RUN) begin
         lo_reg[int'(slice_idx) * SLICE +: SLICE] <= sl_sum;
         carry_reg <= sl_cout;
         slice_idx <= last_slice ? '0 : slice_idx + 1'b1;
         if (last_slice) ovf_run <= sl_cin_msb ^ sl_cout;
      end else if (state == EXT) begin
         result_q <= {hi_sum, lo_reg};
         carry_q  <= carry_reg;
         ovf_q    <= ovf_run;
         zero_q   <= (lo_reg == '0);
         neg_q    <= hi_sum[WIDTH-1];
      end
   end

   assign bus.busy     = (state == RUN) || (state == EXT);
   assign bus.done     = (state == DONE);
   assign bus.result   = result_q;
   assign bus.carry    = carry_q;
   assign bus.overflow = ovf_q;
   assign bus.zero     = zero_q;
   assign bus.negative = neg_q;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Randomised scoreboard bench for seq_addsub_unit (WIDTH=32, SLICE=8).
// Expectations come from plain 64-bit arithmetic and a cycle-count timing model.
module tb_seq_addsub_unit;

   localparam int WIDTH = 32;
   localparam int SLICE = 8;
   localparam int N     = WIDTH / SLICE;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   seq_addsub_unit_if #(.WIDTH(WIDTH)) bus();

   seq_addsub_unit #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [63:0] res;
      logic        c;
      logic        v;
      logic        z;
      logic        n;
      int          due;
   } exp_t;

   exp_t sb[$];
   exp_t held;
   exp_t nodir;
   int   tests    = 0;
   int   fails    = 0;
   int   cyc      = 0;
   int   last_acc = -1000;
   bit   mon_en   = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic sub, input logic sgn,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] ea;
      logic [63:0] eb;
      longint      sa;
      longint      sbv;
      longint      s;
      ea    = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      eb    = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      e.res = sub ? ea - eb : ea + eb;
      e.c   = sub ? (a >= b) : ((64'(a) + 64'(b)) > 64'hFFFF_FFFF);
      sa    = longint'($signed(a));
      sbv   = longint'($signed(b));
      s     = sub ? sa - sbv : sa + sbv;
      e.v   = (s != longint'(int'(s)));
      e.z   = (e.res[31:0] == 32'd0);
      e.n   = e.res[63];
      e.due = 0;
      return e;
   endfunction

   function automatic exp_t mk(input logic [63:0] res, input logic c, input logic v,
                               input logic z, input logic n);
      exp_t e;
      e.res = res; e.c = c; e.v = v; e.z = z; e.n = n; e.due = 0;
      return e;
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // One clock: inputs currently driven are sampled; acceptance decided by timing model.
   task automatic cycle_step(input bit use_dir, input exp_t dir);
      logic        s, rs, sub, sgn;
      logic [31:0] a, b;
      s = bus.start; rs = reset_n; sub = bus.op_sub; sgn = bus.signed_op; a = bus.a; b = bus.b;
      @(posedge clock);
      #1;
      if (!rs) begin
         sb.delete();
         held     = mk(64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         last_acc = -1000;
      end else if (s && (cyc - last_acc) >= N + 2) begin
         exp_t e;
         e     = use_dir ? dir : model(sub, sgn, a, b);
         e.due = cyc + N + 1;
         sb.push_back(e);
         last_acc = cyc;
      end
   endtask

   task automatic randomize_inputs();
      bus.op_sub    = 1'($urandom);
      bus.signed_op = 1'($urandom);
      bus.a         = rnd_op();
      bus.b         = rnd_op();
   endtask

   task automatic issue_dir(input logic sub, input logic sgn, input logic [31:0] a,
                            input logic [31:0] b, input exp_t e);
      bus.start = 1'b1; bus.op_sub = sub; bus.signed_op = sgn; bus.a = a; bus.b = b;
      cycle_step(1'b1, e);
      bus.start = 1'b0;
      repeat (N + 2) begin
         randomize_inputs();
         cycle_step(1'b0, nodir);
      end
   endtask

   always @(negedge clock) begin
      if (mon_en) begin
         int   d;
         exp_t e;
         d = cyc - last_acc;
         chk("busy", 64'(bus.busy), 64'(d >= 0 && d <= N));
         chk("done", 64'(bus.done), 64'(d == N + 1));
         if (bus.done) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_done: done high with no outstanding op at cycle %0d", cyc);
            end else begin
               e = sb.pop_front();
               chk("latency", 64'(cyc), 64'(e.due));
               held = e;
            end
         end
         chk("result",   bus.result,        held.res);
         chk("carry",    64'(bus.carry),    64'(held.c));
         chk("overflow", 64'(bus.overflow), 64'(held.v));
         chk("zero",     64'(bus.zero),     64'(held.z));
         chk("negative", 64'(bus.negative), 64'(held.n));
      end
   end

   initial begin
      nodir = mk(64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      held  = nodir;
      bus.start = 1'b0; bus.op_sub = 1'b0; bus.signed_op = 1'b0; bus.a = '0; bus.b = '0;
      reset_n = 1'b0;
      cycle_step(1'b0, nodir);
      mon_en = 1'b1;
      cycle_step(1'b0, nodir);
      reset_n = 1'b1;
      cycle_step(1'b0, nodir);

      issue_dir(1'b1, 1'b0, 32'd5, 32'd7,
                mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1));
      issue_dir(1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1,
                mk(64'h0000_0000_8000_0000, 1'b0, 1'b1, 1'b0, 1'b0));
      issue_dir(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,
                mk(64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0));
      issue_dir(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1,
                mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1));

      // Start held high: only every N+2 cycles may it be taken.
      bus.start = 1'b1;
      repeat (3 * (N + 2) + 2) begin
         randomize_inputs();
         cycle_step(1'b0, nodir);
      end
      bus.start = 1'b0;
      repeat (N + 2) cycle_step(1'b0, nodir);

      // Reset three edges into an op, with start asserted on the reset edge.
      bus.start = 1'b1;
      randomize_inputs();
      cycle_step(1'b0, nodir);
      bus.start = 1'b0;
      repeat (2) begin
         randomize_inputs();
         cycle_step(1'b0, nodir);
      end
      bus.start = 1'b1;
      reset_n   = 1'b0;
      cycle_step(1'b0, nodir);
      reset_n   = 1'b1;
      bus.start = 1'b0;
      repeat (N + 3) cycle_step(1'b0, nodir);
      bus.start = 1'b1;
      randomize_inputs();
      cycle_step(1'b0, nodir);
      bus.start = 1'b0;
      repeat (N + 2) cycle_step(1'b0, nodir);

      for (int i = 0; i < 2500; i++) begin
         bus.start = ($urandom_range(0, 2) != 0);
         randomize_inputs();
         reset_n = ($urandom_range(0, 199) != 0);
         cycle_step(1'b0, nodir);
         reset_n = 1'b1;
      end

      bus.start = 1'b0;
      repeat (N + 4) cycle_step(1'b0, nodir);
      chk("drain", 64'(sb.size()), 64'd0);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
